// File: rtl/button_conditioner.sv
// Button front end: per-bit 2-flop synchroniser, debounce, press pulse and
// hold-to-auto-repeat. All buttons are handled independently and in parallel.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 10,
  parameter int REPEAT_CYCLES   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HR_W   = $clog2(HR_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
  localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
  localparam logic [HR_W-1:0] RPT_LAST  = HR_W'(REPEAT_CYCLES - 1);
  localparam logic [HR_W-1:0] HR_ONE    = HR_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  // Stage 0/1: metastability chain; only sync2 feeds the debouncer
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DB_W-1:0] db_cnt;
    logic            level_q;
    logic            level_nxt;
    logic            rise;
    logic            fall;
    logic [1:0]      state;
    logic [HR_W-1:0] hold_cnt;
    logic [HR_W-1:0] rpt_cnt;
    logic            pulse_q;
    logic            held_q;

    // The FSM reacts on the same edge the debounced level changes, so the
    // press pulse lines up with the first cycle btn_level is high.
    always_comb begin
      level_nxt = level_q;
      if ((sync2[i] != level_q) && (db_cnt == DB_LAST)) begin
        level_nxt = ~level_q;
      end
    end

    assign rise = level_nxt & ~level_q;
    assign fall = ~level_nxt & level_q;

    // Stage 2: debounce counter and accepted level
    always_ff @(posedge clk) begin
      if (!rst) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync2[i] == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end

    // Stage 3: press / hold / auto-repeat state machine, registered outputs
    always_ff @(posedge clk) begin
      if (!rst) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        rpt_cnt  <= '0;
        pulse_q  <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (fall) begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
          rpt_cnt  <= '0;
          held_q   <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (rise) begin
                pulse_q  <= 1'b1;
                hold_cnt <= '0;
                state    <= ST_HOLD;
              end
            end
            ST_HOLD: begin
              if (hold_cnt == HOLD_LAST) begin
                held_q  <= 1'b1;
                pulse_q <= repeat_en[i];
                rpt_cnt <= '0;
                state   <= ST_REPEAT;
              end else begin
                hold_cnt <= hold_cnt + HR_ONE;
              end
            end
            ST_REPEAT: begin
              // Counter is frozen while repeat is disabled, so re-enabling
              // resumes at the next wrap.
              if (repeat_en[i]) begin
                if (rpt_cnt == RPT_LAST) begin
                  rpt_cnt <= '0;
                  pulse_q <= 1'b1;
                end else begin
                  rpt_cnt <= rpt_cnt + HR_ONE;
                end
              end
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
    assign btn_held[i]  = held_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus
// randomized bouncy stimulus against a window/age-based reference model.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] btn_held;

  int n_assert = 0;
  int n_fail   = 0;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_held(btn_held)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips once the last DB synchronised samples
  // (all taken since the previous flip) disagree with it; pulses and held
  // follow from the press age and the number of repeat-enabled cycles.
  logic [N-1:0]    m_s1, m_s2;
  logic [DB-1:0]   m_win [N];
  int              m_since [N];
  int              m_age [N];
  int              m_en_cnt [N];
  logic [N-1:0]    exp_level, exp_pulse, exp_held;

  task automatic model_step();
    logic [N-1:0] smp;
    logic         old_l;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0;
      exp_level = '0; exp_pulse = '0; exp_held = '0;
      for (int i = 0; i < N; i++) begin
        m_win[i] = '0; m_since[i] = 0; m_age[i] = -1; m_en_cnt[i] = 0;
      end
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      for (int i = 0; i < N; i++) begin
        old_l = exp_level[i];
        m_win[i] = {m_win[i][DB-2:0], smp[i]};
        m_since[i]++;
        if (m_since[i] >= DB && m_win[i] == {DB{~old_l}}) begin
          exp_level[i] = ~old_l;
          m_since[i] = 0;
        end
        exp_pulse[i] = 1'b0;
        if (!old_l && exp_level[i]) begin
          m_age[i] = 0; m_en_cnt[i] = 0; exp_pulse[i] = 1'b1;
        end else if (old_l && !exp_level[i]) begin
          m_age[i] = -1; exp_held[i] = 1'b0;
        end else if (exp_level[i] && m_age[i] >= 0) begin
          if (m_age[i] <= HOLD) m_age[i]++;
          if (m_age[i] == HOLD) begin
            exp_held[i] = 1'b1;
            exp_pulse[i] = repeat_en[i];
          end else if (m_age[i] > HOLD && repeat_en[i]) begin
            m_en_cnt[i]++;
            if (m_en_cnt[i] % RPT == 0) exp_pulse[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] raw, input logic [N-1:0] en);
    @(negedge clk);
    rst = r; btn_raw = raw; repeat_en = en;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, '0, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, N'($urandom), N'($urandom));
      n_assert++;
      if ({btn_level, btn_pulse, btn_held} !== '0) begin
        n_fail++;
        $display("FAIL reset k=%0d got lvl=%b pls=%b held=%b exp all 0", k, btn_level, btn_pulse, btn_held);
      end
    end
    idle(10);
    n_assert++;
    if ({btn_level, btn_pulse, btn_held} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got lvl=%b pls=%b held=%b exp all 0", btn_level, btn_pulse, btn_held);
    end
  endtask

  task automatic test_defaults();
    idle(15);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, (k < 8) ? 5'b00100 : 5'b00000, 5'b00000);
      n_assert++;
      if (btn_pulse !== ((k == 5) ? 5'b00100 : 5'b00000)) begin
        n_fail++;
        $display("FAIL defaults_pulse k=%0d got=%b exp=%b", k, btn_pulse, (k == 5) ? 5'b00100 : 5'b00000);
      end
      n_assert++;
      if (btn_level !== ((k >= 5 && k < 13) ? 5'b00100 : 5'b00000) || btn_held !== exp_held) begin
        n_fail++;
        $display("FAIL defaults_level k=%0d got lvl=%b held=%b exp lvl=%b held=%b", k, btn_level, btn_held,
                 (k >= 5 && k < 13) ? 5'b00100 : 5'b00000, exp_held);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    idle(15);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, {4'b0, (k < 3)}, '0);
      n_assert++;
      if (btn_level[0] !== 1'b0 || btn_pulse[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_short k=%0d got lvl=%b pls=%b exp 0 0", k, btn_level[0], btn_pulse[0]);
      end
    end
    pat = 8'b1111_0111;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, {4'b0, (k < 8) ? pat[k] : 1'b1}, '0);
      n_assert++;
      if (btn_level[0] !== (k >= 9) || btn_pulse[0] !== (k == 9)) begin
        n_fail++;
        $display("FAIL bounce_accept k=%0d got lvl=%b pls=%b exp lvl=%b pls=%b", k, btn_level[0], btn_pulse[0],
                 (k >= 9), (k == 9));
      end
    end
  endtask

  task automatic test_repeat();
    logic ep, eh;
    idle(15);
    for (int k = 0; k < 45; k++) begin
      step(1'b1, (k < 30) ? 5'b01000 : 5'b00000, 5'b01000);
      ep = (k == 5) || (k >= 15 && k < 35 && ((k - 15) % 3 == 0));
      eh = (k >= 15 && k < 35);
      n_assert++;
      if (btn_pulse !== {1'b0, ep, 3'b000} || btn_held !== {1'b0, eh, 3'b000}) begin
        n_fail++;
        $display("FAIL repeat k=%0d got pls=%b held=%b exp pls=%b held=%b", k, btn_pulse, btn_held,
                 {1'b0, ep, 3'b000}, {1'b0, eh, 3'b000});
      end
      n_assert++;
      if (btn_level[3] !== (k >= 5 && k < 35)) begin
        n_fail++;
        $display("FAIL repeat_level k=%0d got=%b exp=%b", k, btn_level[3], (k >= 5 && k < 35));
      end
    end
  endtask

  task automatic test_no_repeat();
    idle(15);
    for (int k = 0; k < 45; k++) begin
      step(1'b1, (k < 30) ? 5'b10000 : 5'b00000, 5'b00000);
      n_assert++;
      if (btn_pulse[4] !== (k == 5) || btn_held[4] !== (k >= 15 && k < 35)) begin
        n_fail++;
        $display("FAIL no_repeat k=%0d got pls=%b held=%b exp pls=%b held=%b", k, btn_pulse[4], btn_held[4],
                 (k == 5), (k >= 15 && k < 35));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] en;
    logic         e;
    idle(15);
    e  = 1'($urandom);
    en = N'($urandom);
    en[2] = e; en[3] = e;
    for (int k = 0; k < 45; k++) begin
      step(1'b1, (k < 25) ? 5'b01100 : 5'b00000, en);
      n_assert++;
      if (btn_pulse[2] !== btn_pulse[3] || btn_pulse !== exp_pulse || btn_held !== exp_held
          || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d got pls=%b held=%b lvl=%b exp pls=%b held=%b lvl=%b", k,
                 btn_pulse, btn_held, btn_level, exp_pulse, exp_held, exp_level);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    idle(15);
    for (int k = 0; k < 25; k++) step(1'b1, 5'b00100, 5'b00100);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 5'b00100, 5'b00100);
      n_assert++;
      if ({btn_level, btn_pulse, btn_held} !== '0) begin
        n_fail++;
        $display("FAIL mid_reset k=%0d got lvl=%b pls=%b held=%b exp all 0", k, btn_level, btn_pulse, btn_held);
      end
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 5'b00100, 5'b00100);
      n_assert++;
      if (btn_pulse !== ((k == 5) ? 5'b00100 : 5'b00000) || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL post_reset k=%0d got pls=%b lvl=%b exp pls=%b lvl=%b", k, btn_pulse, btn_level,
                 (k == 5) ? 5'b00100 : 5'b00000, exp_level);
      end
    end
    idle(10);
  endtask

  task automatic test_random();
    logic [N-1:0] tgt, raw, en, prev_pulse;
    int           dur [N];
    tgt = '0; en = '0; prev_pulse = '0;
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          tgt[i] = ~tgt[i];
          dur[i] = $urandom_range(1, 35);
        end
        dur[i]--;
        raw[i] = ($urandom_range(0, 7) == 0) ? ~tgt[i] : tgt[i];
      end
      if ($urandom_range(0, 49) == 0) en = N'($urandom);
      step((k % 997) != 500, raw, en);
      n_assert++;
      if (btn_level !== exp_level || btn_pulse !== exp_pulse || btn_held !== exp_held) begin
        n_fail++;
        $display("FAIL random k=%0d got lvl=%b pls=%b held=%b exp lvl=%b pls=%b held=%b", k,
                 btn_level, btn_pulse, btn_held, exp_level, exp_pulse, exp_held);
      end
      n_assert++;
      if ((btn_pulse & prev_pulse) !== '0) begin
        n_fail++;
        $display("FAIL random_consecutive k=%0d got=%b exp=%b", k, btn_pulse & prev_pulse, 5'b00000);
      end
      prev_pulse = btn_pulse;
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_bounce();
    test_repeat();
    test_no_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage between the five raw push-buttons (mode, set, inc, dec, light) and the watch core.
- Per button: synchronises the asynchronous input, debounces it, and produces clean one-cycle action pulses.
- Inc/dec get hold-to-auto-repeat so long presses step time-set values continuously.
- The watch core's btn_* inputs are driven from btn_pulse; all buttons are handled independently and in parallel.

Parameters:
- N_BTN, 5, number of buttons; bit order 0=mode, 1=set, 2=inc, 3=dec, 4=light.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (≥1); the top level overrides this for the real clock.
- HOLD_CYCLES, 10, cycles after accepted press before the first auto-repeat / held indication (≥2).
- REPEAT_CYCLES, 3, cycles between successive auto-repeat pulses (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- btn_raw  input  N_BTN  raw, asynchronous, active-high button inputs.
- repeat_en  input  N_BTN  per-button auto-repeat enable; top level ties bits 2,3 high.
- btn_level  output  N_BTN  debounced button level.
- btn_pulse  output  N_BTN  one-cycle pulse on accepted press and on each auto-repeat.
- btn_held  output  N_BTN  high while pressed for ≥HOLD_CYCLES.

Behaviour:
- Reset (rst=0 at a rising edge): synchroniser flops, debounce counters, hold counters, btn_level, btn_pulse and btn_held all go to 0. Reset dominates all other activity.
- Synchroniser: 2-flop chain per bit (sync1 <= btn_raw, sync2 <= sync1); only sync2 is used downstream.
- Debounce, per bit:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == btn_level, the counter clears to 0.
  - Otherwise it increments; on the edge where it would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
  - Any bounce back before that count restarts the count.
- Latency: if btn_raw rises before edge E0 and stays stable, btn_level is high after edge E0+DEBOUNCE_CYCLES+1. Falling edges have the same latency.
- Per-bit FSM, registered outputs:
  - IDLE:
    - On the edge btn_level goes 0→1: btn_pulse=1 for exactly one cycle, hold counter := 0, go to HOLD.
  - HOLD:
    - Hold counter increments each cycle.
    - When it reaches HOLD_CYCLES-1: btn_held := 1.
    - If repeat_en=1, also btn_pulse=1 for one cycle; either way go to REPEAT with the repeat counter := 0.
    - First repeat pulse is HOLD_CYCLES cycles after the press pulse.
  - REPEAT:
    - If repeat_en=1, the repeat counter increments and wraps at REPEAT_CYCLES-1.
    - On each wrap btn_pulse=1 for one cycle, so pulses are spaced REPEAT_CYCLES apart.
    - If repeat_en=0, no pulses are produced; btn_held stays 1.
  - Any state, on the edge btn_level goes 1→0: btn_held := 0, counters clear, go to IDLE, no pulse.
- repeat_en is sampled every cycle. Deasserting it mid-repeat suppresses further pulses; asserting it in REPEAT starts pulses at the next wrap.
- No release pulse is produced.
- btn_pulse is never high for two consecutive cycles when REPEAT_CYCLES ≥ 2; with REPEAT_CYCLES = 1 it stays high continuously in REPEAT.
- Simultaneous presses on different bits are fully independent. No priority or masking is applied; the core resolves conflicts.
- Raw input already high when reset deasserts: treated as a fresh press, with btn_pulse after the normal latency.
- Hold and repeat counters saturate/wrap within width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1); no overflow wrap into IDLE.

Test Plan:
- Defaults. btn_raw[2] 0→1 before edge 0, held 8 cycles, repeat_en=0 → btn_level[2] high after edge 5; btn_pulse[2]=1 only in the cycle after edge 5; all other bits remain 0.
- btn_raw[0] high for 3 cycles, then low (bounce) → btn_level[0] and btn_pulse[0] stay 0 throughout. A bounce pattern 1,1,1,0,1,1,1,1 → btn_level rises only after the final four stable samples.
- repeat_en[3]=1, btn_raw[3] held 30 cycles:
  - Press pulse at cycle P.
  - btn_held[3] and a repeat pulse at P+10, then further pulses at P+13, P+16, P+19, …
  - After release, btn_level falls 5 edges later, with no further pulses and btn_held=0.
- repeat_en[4]=0, btn_raw[4] held 30 cycles → exactly one pulse; btn_held[4] rises at P+10 and stays high until debounced release.
- btn_raw = 5'b01100 pressed together → identical, simultaneous btn_pulse on bits 2 and 3; no cross-interaction.
- rst=0 for 2 cycles mid-repeat with btn_raw[2] still high → all outputs 0 during reset; after reset, a fresh press pulse appears 6 edges after rst returns high.
